// File: rtl/adc_frame_parser.sv
// adc_frame_parser: receive-side parser for the ADC capture stream.
// Each frame arrives as a header {glbl, adc}, N payload words, and a
// trailer {glbl, adc} marked with tlast. The parser strips the header and
// trailer, forwards the payload through a one-entry output register, and
// reports timestamps, payload length and integrity errors for each frame.
module adc_frame_parser #(
  parameter int MAX_PAYLOAD = 8192,
  parameter int LEN_WIDTH   = 16
) (
  input  logic                 clk_245,
  input  logic                 clk_245_rst,
  input  logic                 parser_enable,
  input  logic [63:0]          s_axis_tdata,
  input  logic                 s_axis_tvalid,
  input  logic                 s_axis_tlast,
  output logic                 s_axis_tready,
  output logic [31:0]          sample_lower,
  output logic [31:0]          sample_upper,
  output logic                 sample_valid,
  input  logic                 sample_ready,
  output logic [31:0]          frame_glbl_start,
  output logic [31:0]          frame_adc_start,
  output logic [31:0]          frame_glbl_end,
  output logic [31:0]          frame_adc_end,
  output logic [LEN_WIDTH-1:0] frame_len,
  output logic                 frame_done,
  output logic                 frame_len_err,
  output logic                 err_runt,
  output logic                 err_overrun,
  output logic [15:0]          frame_count,
  output logic                 parser_busy
);

  typedef enum logic [1:0] {
    S_HDR  = 2'd0,
    S_BODY = 2'd1,
    S_DROP = 2'd2
  } state_e;

  localparam logic [LEN_WIDTH-1:0] MAX_CNT = LEN_WIDTH'(MAX_PAYLOAD);

  state_e               state_q, state_d;
  logic [LEN_WIDTH-1:0] cnt_q, cnt_d;
  logic [31:0]          sample_lower_q, sample_lower_d;
  logic [31:0]          sample_upper_q, sample_upper_d;
  logic                 sample_valid_q, sample_valid_d;
  logic [31:0]          glbl_start_q, glbl_start_d;
  logic [31:0]          adc_start_q, adc_start_d;
  logic [31:0]          glbl_end_q, glbl_end_d;
  logic [31:0]          adc_end_q, adc_end_d;
  logic [LEN_WIDTH-1:0] frame_len_q, frame_len_d;
  logic                 frame_len_err_q, frame_len_err_d;
  logic                 frame_done_q, frame_done_d;
  logic                 err_runt_q, err_runt_d;
  logic                 err_overrun_q, err_overrun_d;
  logic [15:0]          frame_count_q, frame_count_d;

  logic                 tready_c;
  logic                 accept;
  logic                 load;

  // Ready depends only on registered state, enable and the downstream
  // ready, never on s_axis_tvalid.
  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a default
    // first; a path that leaves it unassigned would infer a latch.
    tready_c = 1'b0;
    case (state_q)
      S_HDR:   tready_c = parser_enable;
      S_BODY:  tready_c = !sample_valid_q | sample_ready;
      S_DROP:  tready_c = 1'b1;
      default: tready_c = 1'b0;
    endcase
  end

  // Hold ready low while reset is asserted so every output reads 0.
  assign s_axis_tready = tready_c & !clk_245_rst;
  assign accept        = s_axis_tvalid & tready_c;

  // Frame state machine: next state, counters and frame statistics.
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    load            = 1'b0;
    glbl_start_d    = glbl_start_q;
    adc_start_d     = adc_start_q;
    glbl_end_d      = glbl_end_q;
    adc_end_d       = adc_end_q;
    frame_len_d     = frame_len_q;
    frame_len_err_d = frame_len_err_q;
    frame_done_d    = 1'b0;
    err_runt_d      = 1'b0;
    err_overrun_d   = 1'b0;
    frame_count_d   = frame_count_q;

    case (state_q)
      S_HDR: begin
        if (accept) begin
          if (s_axis_tlast) begin
            err_runt_d = 1'b1;
          end else begin
            glbl_start_d = s_axis_tdata[63:32];
            adc_start_d  = s_axis_tdata[31:0];
            cnt_d        = '0;
            state_d      = S_BODY;
          end
        end
      end

      S_BODY: begin
        if (accept) begin
          if (s_axis_tlast) begin
            // The adc counter advances once per payload word plus once for
            // the trailer; modulo-2^32 subtraction makes a wrap harmless.
            glbl_end_d      = s_axis_tdata[63:32];
            adc_end_d       = s_axis_tdata[31:0];
            frame_len_d     = cnt_q;
            frame_len_err_d = (s_axis_tdata[31:0] - adc_start_q) !=
                              (32'(cnt_q) + 32'd1);
            frame_done_d    = 1'b1;
            frame_count_d   = frame_count_q + 16'd1;
            state_d         = S_HDR;
          end else if (cnt_q == MAX_CNT) begin
            err_overrun_d = 1'b1;
            state_d       = S_DROP;
          end else begin
            load  = 1'b1;
            cnt_d = cnt_q + LEN_WIDTH'(1);
          end
        end
      end

      S_DROP: begin
        if (accept && s_axis_tlast) begin
          state_d = S_HDR;
        end
      end

      default: state_d = S_HDR;
    endcase
  end

  // One-entry output register: a load and a drain in the same cycle keep
  // valid high, giving one sample per clock while sample_ready stays high.
  always_comb begin
    sample_valid_d = load | (sample_valid_q & !sample_ready);
    sample_lower_d = load ? s_axis_tdata[31:0]  : sample_lower_q;
    sample_upper_d = load ? s_axis_tdata[63:32] : sample_upper_q;
  end

  // State and output registers with asynchronous active-high reset.
  always_ff @(posedge clk_245 or posedge clk_245_rst) begin
    if (clk_245_rst) begin
      state_q         <= S_HDR;
      cnt_q           <= '0;
      sample_lower_q  <= '0;
      sample_upper_q  <= '0;
      sample_valid_q  <= 1'b0;
      glbl_start_q    <= '0;
      adc_start_q     <= '0;
      glbl_end_q      <= '0;
      adc_end_q       <= '0;
      frame_len_q     <= '0;
      frame_len_err_q <= 1'b0;
      frame_done_q    <= 1'b0;
      err_runt_q      <= 1'b0;
      err_overrun_q   <= 1'b0;
      frame_count_q   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      sample_lower_q  <= sample_lower_d;
      sample_upper_q  <= sample_upper_d;
      sample_valid_q  <= sample_valid_d;
      glbl_start_q    <= glbl_start_d;
      adc_start_q     <= adc_start_d;
      glbl_end_q      <= glbl_end_d;
      adc_end_q       <= adc_end_d;
      frame_len_q     <= frame_len_d;
      frame_len_err_q <= frame_len_err_d;
      frame_done_q    <= frame_done_d;
      err_runt_q      <= err_runt_d;
      err_overrun_q   <= err_overrun_d;
      frame_count_q   <= frame_count_d;
    end
  end

  assign sample_lower     = sample_lower_q;
  assign sample_upper     = sample_upper_q;
  assign sample_valid     = sample_valid_q;
  assign frame_glbl_start = glbl_start_q;
  assign frame_adc_start  = adc_start_q;
  assign frame_glbl_end   = glbl_end_q;
  assign frame_adc_end    = adc_end_q;
  assign frame_len        = frame_len_q;
  assign frame_len_err    = frame_len_err_q;
  assign frame_done       = frame_done_q;
  assign err_runt         = err_runt_q;
  assign err_overrun      = err_overrun_q;
  assign frame_count      = frame_count_q;
  assign parser_busy      = (state_q == S_BODY) | (state_q == S_DROP);

endmodule

// File: tb/tb_adc_frame_parser.sv
// Self-checking bench for adc_frame_parser: directed frames plus randomized
// frames, compared against a frame-level reference model.
module tb_adc_frame_parser;

  localparam int MAXP = 8;
  localparam int LW   = 16;

  logic          clk;
  logic          rst;
  logic          parser_enable;
  logic [63:0]   s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tlast;
  logic          s_axis_tready;
  logic [31:0]   sample_lower;
  logic [31:0]   sample_upper;
  logic          sample_valid;
  logic          sample_ready;
  logic [31:0]   frame_glbl_start;
  logic [31:0]   frame_adc_start;
  logic [31:0]   frame_glbl_end;
  logic [31:0]   frame_adc_end;
  logic [LW-1:0] frame_len;
  logic          frame_done;
  logic          frame_len_err;
  logic          err_runt;
  logic          err_overrun;
  logic [15:0]   frame_count;
  logic          parser_busy;

  adc_frame_parser #(.MAX_PAYLOAD(MAXP), .LEN_WIDTH(LW)) dut (
    .clk_245          (clk),
    .clk_245_rst      (rst),
    .parser_enable    (parser_enable),
    .s_axis_tdata     (s_axis_tdata),
    .s_axis_tvalid    (s_axis_tvalid),
    .s_axis_tlast     (s_axis_tlast),
    .s_axis_tready    (s_axis_tready),
    .sample_lower     (sample_lower),
    .sample_upper     (sample_upper),
    .sample_valid     (sample_valid),
    .sample_ready     (sample_ready),
    .frame_glbl_start (frame_glbl_start),
    .frame_adc_start  (frame_adc_start),
    .frame_glbl_end   (frame_glbl_end),
    .frame_adc_end    (frame_adc_end),
    .frame_len        (frame_len),
    .frame_done       (frame_done),
    .frame_len_err    (frame_len_err),
    .err_runt         (err_runt),
    .err_overrun      (err_overrun),
    .frame_count      (frame_count),
    .parser_busy      (parser_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_mis = 0;

  // Cycle index: number of rising edges seen so far.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Downstream ready pattern: 0 always 1, 1 toggle, 2 random, 3 always 0.
  int ready_mode = 0;
  initial begin
    sample_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       sample_ready = 1'b1;
        1:       sample_ready = !sample_ready;
        2:       sample_ready = 1'($urandom_range(0, 1));
        default: sample_ready = 1'b0;
      endcase
    end
  end

  // Observation side: collect transferred samples and event pulses.
  logic [63:0] obs_q[$];
  int          obs_cyc[$];
  int          done_cnt = 0, runt_cnt = 0, ovr_cnt = 0;
  int          done_cyc = 0;
  int          stall_chk = 0, stall_err = 0;
  logic [LW-1:0] cap_len;
  logic        cap_err;
  bit          prev_stall = 0;
  logic [63:0] prev_data;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        stall_chk++;
        if (!sample_valid || {sample_upper, sample_lower} !== prev_data) stall_err++;
      end
      if (sample_valid && sample_ready) begin
        obs_q.push_back({sample_upper, sample_lower});
        obs_cyc.push_back(cyc);
      end
      prev_stall = sample_valid && !sample_ready;
      prev_data  = {sample_upper, sample_lower};
      if (frame_done) begin
        done_cnt++;
        done_cyc = cyc;
        cap_len  = frame_len;
        cap_err  = frame_len_err;
      end
      if (err_runt) runt_cnt++;
      if (err_overrun) ovr_cnt++;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one word and hold it until accepted; returns the index of the
  // rising edge on which it transferred.
  task automatic send_word(input logic [63:0] d, input logic last, output int acc_idx);
    bit acc = 0;
    acc_idx = -1;
    s_axis_tdata  = d;
    s_axis_tlast  = last;
    s_axis_tvalid = 1'b1;
    for (int b = 0; b < 200 && !acc; b++) begin
      @(negedge clk);
      if (s_axis_tready) begin
        acc_idx = cyc + 1;
        acc = 1;
      end
      @(posedge clk);
      #1;
    end
    if (!acc) check("handshake_timeout", 64'd0, 64'd1);
  endtask

  task automatic idle(input int cycles);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  int          acc_q[$];
  int          last_trl_idx;
  logic [15:0] exp_fc = 16'd0;

  // Send one frame and compare against the frame-level model: the first
  // min(n, MAXP) payload words come out in order; n > MAXP means overrun
  // and no frame_done; otherwise frame_len = n and the error flag reflects
  // whether the adc span differs from n+1 modulo 2^32.
  task automatic run_frame(input string name, input logic [31:0] hg, input logic [31:0] ha,
                           input logic [31:0] tg, input logic [31:0] ta, input int n);
    logic [63:0] pay[$];
    logic [63:0] d;
    int idx, d0, o0, n_out;
    bit ovr;
    logic [31:0] span;
    obs_q.delete();
    obs_cyc.delete();
    acc_q.delete();
    d0 = done_cnt;
    o0 = ovr_cnt;
    send_word({hg, ha}, 1'b0, idx);
    for (int i = 0; i < n; i++) begin
      d = {$urandom, $urandom};
      pay.push_back(d);
      send_word(d, 1'b0, idx);
      acc_q.push_back(idx);
    end
    send_word({tg, ta}, 1'b1, last_trl_idx);
    idle(20);

    ovr   = (n > MAXP);
    n_out = ovr ? MAXP : n;
    span  = ta - ha;
    check($sformatf("%s:nsamp", name), 64'(obs_q.size()), 64'(n_out));
    for (int i = 0; i < n_out && i < obs_q.size(); i++)
      check($sformatf("%s:sample%0d", name, i), obs_q[i], pay[i]);
    check($sformatf("%s:overrun", name), 64'(ovr_cnt - o0), 64'(ovr ? 1 : 0));
    check($sformatf("%s:done", name), 64'(done_cnt - d0), 64'(ovr ? 0 : 1));
    check($sformatf("%s:glbl_start", name), 64'(frame_glbl_start), 64'(hg));
    check($sformatf("%s:adc_start", name), 64'(frame_adc_start), 64'(ha));
    if (!ovr) begin
      exp_fc = exp_fc + 16'd1;
      check($sformatf("%s:len", name), 64'(cap_len), 64'(n));
      check($sformatf("%s:len_err", name), 64'(cap_err), 64'(span != 32'(n + 1)));
      check($sformatf("%s:len_hold", name), 64'(frame_len), 64'(n));
      check($sformatf("%s:glbl_end", name), 64'(frame_glbl_end), 64'(tg));
      check($sformatf("%s:adc_end", name), 64'(frame_adc_end), 64'(ta));
    end
    check($sformatf("%s:frame_count", name), 64'(frame_count), 64'(exp_fc));
    check($sformatf("%s:busy_after", name), 64'(parser_busy), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int idx, r0, d0, n;
    logic [31:0] ha, ta;

    // Reset: outputs must be 0 even with parser_enable high.
    rst           = 1'b1;
    parser_enable = 1'b1;
    s_axis_tdata  = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst:tready", 64'(s_axis_tready), 64'd0);
    check("rst:sample_valid", 64'(sample_valid), 64'd0);
    check("rst:frame_count", 64'(frame_count), 64'd0);
    check("rst:frame_len", 64'(frame_len), 64'd0);
    check("rst:busy", 64'(parser_busy), 64'd0);
    rst = 1'b0;

    // Disabled at idle: offered words are not accepted.
    parser_enable = 1'b0;
    s_axis_tdata  = {32'h1, 32'h2};
    s_axis_tvalid = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("disabled:tready", 64'(s_axis_tready), 64'd0);
    check("disabled:busy", 64'(parser_busy), 64'd0);
    idle(1);
    parser_enable = 1'b1;
    @(negedge clk);
    check("enabled:tready", 64'(s_axis_tready), 64'd1);
    @(posedge clk);
    #1;

    // Basic frame, full throughput, latency checks.
    ready_mode = 0;
    run_frame("basic", 32'h100, 32'h10, 32'h106, 32'h15, 4);
    for (int i = 0; i < 4 && i < obs_cyc.size() && i < acc_q.size(); i++)
      check($sformatf("basic:lat%0d", i), 64'(obs_cyc[i]), 64'(acc_q[i]));
    check("basic:done_lat", 64'(done_cyc), 64'(last_trl_idx));

    run_frame("span_bad", 32'h100, 32'h10, 32'h106, 32'h17, 4);
    run_frame("wrap", 32'h7, 32'hFFFF_FFFE, 32'h9, 32'h2, 3);

    // Backpressure with alternating ready; exactly MAXP words fits.
    ready_mode = 1;
    r0 = stall_chk;
    d0 = stall_err;
    run_frame("toggle", 32'h20, 32'h30, 32'h29, 32'h39, 8);
    check("toggle:stalls_seen", 64'(stall_chk > r0), 64'd1);
    check("toggle:stall_stable", 64'(stall_err - d0), 64'd0);
    ready_mode = 0;

    // Runt: tlast on a header word.
    r0 = runt_cnt;
    d0 = done_cnt;
    send_word({32'hAA, 32'hBB}, 1'b1, idx);
    idle(4);
    check("runt:pulse", 64'(runt_cnt - r0), 64'd1);
    check("runt:no_done", 64'(done_cnt - d0), 64'd0);
    check("runt:busy", 64'(parser_busy), 64'd0);

    // Overrun, then a normal frame and zero-payload frames.
    run_frame("overrun", 32'h40, 32'h50, 32'h4B, 32'h5B, 10);
    run_frame("post_ovr", 32'h60, 32'h70, 32'h63, 32'h73, 2);
    run_frame("zero_ok", 32'h200, 32'h300, 32'h201, 32'h301, 0);
    run_frame("zero_bad", 32'h200, 32'h300, 32'h201, 32'h303, 0);

    // Randomized frames under random backpressure.
    ready_mode = 2;
    for (int f = 0; f < 6; f++) begin
      n  = int'($urandom_range(0, 10));
      ha = $urandom;
      ta = ha + 32'(n + 1);
      if ($urandom_range(0, 1) == 1) ta = ta + 32'($urandom_range(1, 5));
      run_frame($sformatf("rand%0d", f), $urandom, ha, $urandom, ta, n);
    end

    // Reset mid-frame with a sample pending.
    ready_mode = 3;
    @(posedge clk);
    #1;
    send_word({32'h500, 32'h600}, 1'b0, idx);
    send_word({32'hDEAD, 32'hBEEF}, 1'b0, idx);
    s_axis_tvalid = 1'b0;
    @(negedge clk);
    check("midrst:pending", 64'(sample_valid), 64'd1);
    check("midrst:busy_before", 64'(parser_busy), 64'd1);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("midrst:sample_valid", 64'(sample_valid), 64'd0);
    check("midrst:sample_data", {sample_upper, sample_lower}, 64'd0);
    check("midrst:adc_start", 64'(frame_adc_start), 64'd0);
    check("midrst:frame_count", 64'(frame_count), 64'd0);
    check("midrst:tready", 64'(s_axis_tready), 64'd0);
    check("midrst:busy", 64'(parser_busy), 64'd0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    exp_fc = 16'd0;
    ready_mode = 0;
    @(posedge clk);
    #1;
    run_frame("after_rst", 32'h700, 32'h800, 32'h704, 32'h804, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/adc_frame_parser.md
Name: adc_frame_parser

Overview:
Receive-side counterpart of the ADC capture framer. Consumes the 64-bit ADC capture stream as AXI-Stream frames. Each frame is one header word {glbl_counter, adc_counter}, then N payload words {data_out_upper, data_out_lower}, then one trailer word {glbl_counter, adc_counter} marked with tlast. The block strips the header and trailer, forwards payload as lower/upper 32-bit lanes with a valid/ready handshake, and reports per-frame timestamps, payload length and integrity errors. It sits in the clk_245 domain, ahead of the FFT/processing path and the loopback checkers.

Parameters:
- MAX_PAYLOAD, 8192, payload words allowed per frame before overrun.
- LEN_WIDTH, 16, width of the payload counter and frame_len (must hold MAX_PAYLOAD).

Ports:
- clk_245  in  1  sole clock.
- clk_245_rst  in  1  asynchronous reset, active-high.
- parser_enable  in  1  permits start of a new frame.
- s_axis_tdata  in  64  frame word.
- s_axis_tvalid  in  1  word valid.
- s_axis_tlast  in  1  marks trailer word.
- s_axis_tready  out  1  word accepted when tvalid&tready.
- sample_lower  out  32  payload bits [31:0].
- sample_upper  out  32  payload bits [63:32].
- sample_valid  out  1  payload output valid.
- sample_ready  in  1  downstream accept.
- frame_glbl_start  out  32  header [63:32].
- frame_adc_start  out  32  header [31:0].
- frame_glbl_end  out  32  trailer [63:32].
- frame_adc_end  out  32  trailer [31:0].
- frame_len  out  LEN_WIDTH  payload words in last completed frame.
- frame_done  out  1  one-cycle pulse, frame statistics updated.
- frame_len_err  out  1  valid with frame_done; adc counter span mismatch.
- err_runt  out  1  one-cycle pulse, tlast on header word.
- err_overrun  out  1  one-cycle pulse, payload exceeded MAX_PAYLOAD.
- frame_count  out  16  completed frames, wraps 0xFFFF->0.
- parser_busy  out  1  high in S_BODY or S_DROP.

Behaviour:
- Reset, asynchronous: all outputs 0, state S_HDR, output register empty, counters 0.
- A word transfers on s_axis_tvalid & s_axis_tready. No combinational path from s_axis_tvalid to s_axis_tready.
- S_HDR:
  - s_axis_tready = parser_enable.
  - An accepted word with tlast=0 latches frame_glbl_start and frame_adc_start, clears the payload counter, and moves to S_BODY.
  - An accepted word with tlast=1 pulses err_runt next cycle and stays in S_HDR.
- S_BODY:
  - s_axis_tready = !sample_valid | sample_ready (one-entry output register).
  - An accepted word with tlast=0 is payload. It loads sample_lower and sample_upper, sets sample_valid next cycle, and increments the payload counter.
  - Accepted payload that would make the count exceed MAX_PAYLOAD is dropped (not output). err_overrun pulses and the state moves to S_DROP.
  - An accepted word with tlast=1 is the trailer and produces no sample. Next cycle:
    - latch frame_glbl_end and frame_adc_end;
    - frame_len = payload count;
    - frame_len_err = ((trailer[31:0] - header[31:0]) mod 2^32) != count+1;
    - pulse frame_done; frame_count+1; return to S_HDR.
  - parser_enable is ignored mid-frame.
- S_DROP: s_axis_tready=1 and all words are discarded. An accepted tlast returns to S_HDR. No frame_done is generated.
- Output register:
  - sample_valid clears on sample_ready when no new payload loads that cycle.
  - Simultaneous drain and load gives back-to-back valid with no bubble. Full throughput is 1 word/clk while sample_ready=1.
  - Data is held stable while sample_valid & !sample_ready.
- Latency: payload word to sample_valid is 1 clk. Trailer to frame_done is 1 clk.
- frame_done statistics hold until the next frame_done. A pending output sample may still be draining when frame_done pulses; this is legal.
- Subtraction is unsigned modulo 2^32, so a counter wrap between header and trailer is not an error.
- Zero-payload frame (header then trailer): frame_len=0, no samples, frame_len_err set unless the span is 1.

Test Plan:
- Header {0x100,0x10}, 4 payload words, trailer {0x106,0x15}, tlast, sample_ready=1 -> 4 samples, one per clk, 1-clk latency; frame_done with frame_len=4, frame_len_err=0, frame_count=1.
- Same frame with trailer adc=0x17 -> frame_done, frame_len_err=1.
- Header adc=0xFFFFFFFE, 3 payload, trailer adc=0x2 -> frame_len_err=0 (wrap).
- sample_ready toggled 1010..., 8 payload words -> s_axis_tready follows the output register, no sample lost or duplicated, data stable while stalled.
- Single tlast word in S_HDR -> err_runt pulse, no frame_done. MAX_PAYLOAD=4 with 6 payload words -> 4 samples, err_overrun, rest dropped through tlast, next frame parses normally.
- parser_enable=0 at idle -> tready=0. clk_245_rst asserted mid-frame -> all outputs 0 immediately, then the next header parses correctly.
